// File: rtl/pipe_pkg.sv
// Shared definitions for the handshaked pipeline stage register.
// Contents:
//   PIPE_RESET_PC / PIPE_NOP_INSTR : default reset PC and bubble instruction
//   PIPE_*_W                       : default payload field widths
//   pipe_payload_t                 : {pc, instr, side} at the default widths
package pipe_pkg;

  localparam logic [31:0] PIPE_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] PIPE_NOP_INSTR = 32'h0000_0000;

  localparam int PIPE_PC_W    = 32;
  localparam int PIPE_INSTR_W = 32;
  localparam int PIPE_SIDE_W  = 8;

  typedef struct packed {
    logic [PIPE_PC_W-1:0]    pc;
    logic [PIPE_INSTR_W-1:0] instr;
    logic [PIPE_SIDE_W-1:0]  side;
  } pipe_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register with its valid bit.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   clear         : invalidate and reload RESET_DATA (flush)
//   load, d       : capture d and mark valid
//   unload        : entry consumed with no replacement; data is kept so the
//                   stage can keep presenting the last PC during a bubble
//   valid, q      : slot state
// Priority: reset/clear > load > unload.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int         W          = 1,
  parameter logic [W-1:0] RESET_DATA = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
      q     <= RESET_DATA;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline stage register carrying {pc, instr, side}.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : kill held entries, drop any input accepted now
//   in_valid / in_ready   : upstream handshake; in_pc, in_instr, in_side payload
//   out_valid / out_ready : downstream handshake; out_pc, out_instr, out_side
// Configuration macro PIPE_STAGE_SKID_EN:
//   defined   -> main + skid slot, in_ready = !skid_valid (registered)
//   undefined -> single slot, in_ready = !out_valid | out_ready
// While out_valid=0, out_instr shows NOP_INSTR and out_side shows 0; out_pc
// keeps the last entry's PC (RESET_PC after reset/flush).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PC_W      = 32,
  parameter int          INSTR_W   = 32,
  parameter int          SIDE_W    = 8,
  parameter logic [31:0] RESET_PC  = PIPE_RESET_PC,
  parameter logic [31:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [SIDE_W-1:0]  in_side,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [SIDE_W-1:0]  out_side
);

  localparam int W = PC_W + INSTR_W + SIDE_W;
  localparam logic [W-1:0] RESET_DATA =
    {RESET_PC[PC_W-1:0], NOP_INSTR[INSTR_W-1:0], {SIDE_W{1'b0}}};

  logic         main_v;
  logic [W-1:0] main_q;
  logic         main_load;
  logic [W-1:0] main_d;
  logic         in_hs;
  logic         out_hs;
  logic [W-1:0] in_data;

  assign in_data = {in_pc, in_instr, in_side};
  assign in_hs   = in_valid & in_ready;
  assign out_hs  = main_v & out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic         skid_v;
  logic [W-1:0] skid_q;
  logic         skid_load;

  assign in_ready  = !skid_v;
  // Skid has priority for main: it holds the older entry. in_hs is already
  // blocked while skid is full, so the two load sources never collide.
  assign main_load = (skid_v & out_hs) | (in_hs & (!main_v | out_hs));
  assign main_d    = skid_v ? skid_q : in_data;
  assign skid_load = in_hs & main_v & !out_hs;

  pipe_slot #(.W(W), .RESET_DATA(RESET_DATA)) u_skid (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (skid_load),
    .unload (skid_v & out_hs),
    .d      (in_data),
    .valid  (skid_v),
    .q      (skid_q)
  );
`else
  assign in_ready  = !main_v | out_ready;
  assign main_load = in_hs & (!main_v | out_hs);
  assign main_d    = in_data;
`endif

  pipe_slot #(.W(W), .RESET_DATA(RESET_DATA)) u_main (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .load   (main_load),
    .unload (out_hs),
    .d      (main_d),
    .valid  (main_v),
    .q      (main_q)
  );

  assign out_valid = main_v;
  assign out_pc    = main_q[W-1 -: PC_W];
  assign out_instr = main_v ? main_q[SIDE_W +: INSTR_W] : NOP_INSTR[INSTR_W-1:0];
  assign out_side  = main_v ? main_q[SIDE_W-1:0] : '0;

endmodule
